// File: rtl/uart_fifo_pkg.sv
// Shared constants, count-width helper and register-map status struct for the UART FIFO.
package uart_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Occupancy needs to represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic geqth;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Dual-port storage: synchronous write, registered read with enable; BYPASS forwards
// a same-cycle write to the read register when addresses match. Array itself is never reset.
module uart_fifo_ram
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter bit BYPASS = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (BYPASS && wr_en && (wr_addr == rd_addr)) rd_data <= wr_data;
      else                                          rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_fifo_param.sv
// Parametrised UART FIFO with 1-cycle registered read; writes when full set sticky OVERFLOW,
// reads when empty set sticky UNDERFLOW. Define UART_FIFO_FWFT_EN for first-word-fall-through.
module uart_fifo_param
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [WIDTH-1:0]        DIN,
  input  logic                    WRB,
  input  logic                    RDB,
  input  logic [cnt_w(DEPTH)-1:0] THRESH,
  input  logic                    CLR_ERR,
  output logic [WIDTH-1:0]        DOUT,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic                    ALMOST_FULL,
  output logic                    ALMOST_EMPTY,
  output logic                    GEQTH,
  output logic [cnt_w(DEPTH)-1:0] COUNT,
  output logic                    OVERFLOW,
  output logic                    UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

`ifdef UART_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, ram_rd_addr;
  logic [CW-1:0] count;
  logic          wr_acc, rd_acc, ovf, unf, ram_rd_en;
  fifo_status_t  st;

  always_comb begin
    st              = '0;
    st.full         = (count == CW'(DEPTH));
    st.empty        = (count == '0);
    st.almost_full  = (int'(count) >= DEPTH - AF_MARGIN);
    st.almost_empty = (int'(count) <= AE_MARGIN);
    st.geqth        = (count >= THRESH);
    st.overflow     = ovf;
    st.underflow    = unf;
  end

  // A read frees a slot in the same cycle, so a full FIFO still takes a concurrent write.
  assign rd_acc     = !RDB && !st.empty;
  assign wr_acc     = !WRB && (!st.full || rd_acc);
  assign rd_ptr_nxt = rd_acc ? rd_ptr + AW'(1) : rd_ptr;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      if (wr_acc && !rd_acc)      count <= count + CW'(1);
      else if (rd_acc && !wr_acc) count <= count - CW'(1);
      ovf <= (!WRB && !wr_acc) || (ovf && !CLR_ERR);
      unf <= (!RDB && !rd_acc) || (unf && !CLR_ERR);
    end
  end

  // Fall-through keeps the read register loaded with the post-edge head entry.
  assign ram_rd_en   = FWFT ? 1'b1 : rd_acc;
  assign ram_rd_addr = FWFT ? rd_ptr_nxt : rd_ptr;

  uart_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .BYPASS (FWFT)
  ) u_ram (
    .clk     (CLK),
    .rst_n   (RESET),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (DIN),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (DOUT)
  );

  assign FULL         = st.full;
  assign EMPTY        = st.empty;
  assign ALMOST_FULL  = st.almost_full;
  assign ALMOST_EMPTY = st.almost_empty;
  assign GEQTH        = st.geqth;
  assign OVERFLOW     = st.overflow;
  assign UNDERFLOW    = st.underflow;
  assign COUNT        = count;

endmodule
